// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the immediate generator pipeline: selector and buffer-state enums
// plus the request payload fed to the formation logic.
package imm_gen_pipe_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned SEL_W   = 3;

   typedef enum logic [SEL_W-1:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_sel_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b01,
      BUF_FULL  = 2'b10
   } buf_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      imm_sel_e           sel;
   } form_req_t;

endpackage

// File: rtl/imm_gen_pipe_imm_form.sv
// Combinational RISC-V immediate formation, sign-extended to XLEN.
// IMM_GEN_ILLEGAL_CHK_EN: illegal selectors yield imm 0 and illegal 1; otherwise they decode as I-type.
module imm_form
   import imm_gen_pipe_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  form_req_t        req_i,
   output logic [XLEN-1:0]  imm_o,
   output logic             illegal_o
);

   logic [INSTR_W-1:0] ins;
   logic [31:0]        raw;

   assign ins = req_i.instr;

   always_comb begin
      raw       = '0;
      illegal_o = 1'b0;
      case (req_i.sel)
         IMM_I: raw = {{20{ins[31]}}, ins[31:20]};
         IMM_S: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B: raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_J: raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         IMM_U: raw = {ins[31:12], 12'h000};
         default: begin
`ifdef IMM_GEN_ILLEGAL_CHK_EN
            raw       = '0;
            illegal_o = 1'b1;
`else
            raw       = {{20{ins[31]}}, ins[31:20]};
`endif
         end
      endcase
   end

   // raw is already sign-extended to 32 bits; widen further for XLEN=64
   assign imm_o = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry in-order output buffer (output + skid register).
// Optional IMM_GEN_ILLEGAL_CHK_EN flags illegal selectors (see imm_form).
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic [TAG_W-1:0]   in_tag,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_imm,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_illegal
);

   form_req_t        req;
   logic [XLEN-1:0]  new_imm;
   logic             new_ill;

   buf_state_e       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d;
   logic             out_ill_q, out_ill_d;
   logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
   logic             skid_ill_q, skid_ill_d;

   logic             acc, drn;

   assign req.instr = in_instr;
   assign req.sel   = imm_sel_e'(in_sel);

   imm_form #(.XLEN(XLEN)) u_form (
      .req_i     (req),
      .imm_o     (new_imm),
      .illegal_o (new_ill)
   );

   assign acc = in_valid & in_ready_q;
   assign drn = out_valid_q & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= BUF_EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_imm_q   <= '0;
         out_tag_q   <= '0;
         out_ill_q   <= 1'b0;
         skid_imm_q  <= '0;
         skid_tag_q  <= '0;
         skid_ill_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_imm_q   <= out_imm_d;
         out_tag_q   <= out_tag_d;
         out_ill_q   <= out_ill_d;
         skid_imm_q  <= skid_imm_d;
         skid_tag_q  <= skid_tag_d;
         skid_ill_q  <= skid_ill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_ill_d  = out_ill_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_ill_d = skid_ill_q;

      case (state_q)
         BUF_EMPTY: begin
            if (acc) begin
               out_imm_d = new_imm;
               out_tag_d = in_tag;
               out_ill_d = new_ill;
               state_d   = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (acc && !drn) begin
               skid_imm_d = new_imm;
               skid_tag_d = in_tag;
               skid_ill_d = new_ill;
               state_d    = BUF_FULL;
            end else if (acc && drn) begin
               out_imm_d = new_imm;
               out_tag_d = in_tag;
               out_ill_d = new_ill;
            end else if (drn) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (drn) begin
               out_imm_d = skid_imm_q;
               out_tag_d = skid_tag_q;
               out_ill_d = skid_ill_q;
               state_d   = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase

      if (flush) begin
         state_d = BUF_EMPTY;
      end

      // an empty buffer presents all-zero payload
      if (state_d == BUF_EMPTY) begin
         out_imm_d = '0;
         out_tag_d = '0;
         out_ill_d = 1'b0;
      end

      out_valid_d = (state_d != BUF_EMPTY);
      in_ready_d  = (state_d != BUF_FULL);
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_imm_q;
   assign out_tag     = out_tag_q;
   assign out_illegal = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32): formation, buffering, flush and reset.
module tb_imm_gen_pipe;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [2:0]       in_sel;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   int nvec = 0;
   int nerr = 0;

   imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_sel      (in_sel),
      .in_tag      (in_tag),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_tag     (out_tag),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_sel    = '0;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      #2;
      nvec++;
      if ({in_ready, out_valid, out_illegal} !== 3'b000 || out_imm !== '0 || out_tag !== '0) begin
         $display("FAIL reset_outputs: rdy=%b vld=%b ill=%b imm=%h tag=%h, need all 0",
                  in_ready, out_valid, out_illegal, out_imm, out_tag);
         nerr++;
      end
      step();
      step();
      #2 reset = 1'b0;
      in_valid = 1'b1;
      in_instr = 32'hFFF00093;
      in_tag   = 5'd9;
      nvec++;
      if (in_ready !== 1'b0) begin
         $display("FAIL release_ready: in_ready=%b, need 0", in_ready);
         nerr++;
      end
      step();
      nvec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL first_edge: in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
         nerr++;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_check(input string name, input logic [31:0] instr, input logic [2:0] sel,
                             input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_imm,
                             input logic exp_ill);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = instr;
      in_sel    = sel;
      in_tag    = tag;
      step();
      in_valid = 1'b0;
      nvec++;
      if (out_valid !== 1'b1 || out_imm !== exp_imm || out_tag !== tag || out_illegal !== exp_ill) begin
         $display("FAIL %s: vld=%b imm=%h tag=%h ill=%b, need 1 %h %h %b",
                  name, out_valid, out_imm, out_tag, out_illegal, exp_imm, tag, exp_ill);
         nerr++;
      end
      step();
      nvec++;
      if (out_valid !== 1'b0 || out_imm !== '0 || out_tag !== '0 || out_illegal !== 1'b0) begin
         $display("FAIL %s_idle: vld=%b imm=%h tag=%h ill=%b, need 0 0 0 0",
                  name, out_valid, out_imm, out_tag, out_illegal);
         nerr++;
      end
   endtask

   task automatic test_formation();
      send_check("imm_i_neg", 32'hFFF00093, 3'b000, 5'd1, 32'hFFFFFFFF, 1'b0);
      send_check("imm_s_pos", 32'h00A12423, 3'b001, 5'd2, 32'h00000008, 1'b0);
      send_check("imm_b_neg", 32'hFE000EE3, 3'b010, 5'd3, 32'hFFFFFFFC, 1'b0);
      send_check("imm_j_pos", 32'h0080006F, 3'b011, 5'd4, 32'h00000008, 1'b0);
      send_check("imm_j_neg", 32'hFFDFF06F, 3'b011, 5'd5, 32'hFFFFFFFC, 1'b0);
      send_check("imm_u_neg", 32'h800000B7, 3'b100, 5'd6, 32'h80000000, 1'b0);
   endtask

   task automatic test_illegal();
`ifdef IMM_GEN_ILLEGAL_CHK_EN
      send_check("illegal_111", 32'h00500093, 3'b111, 5'd7, 32'h00000000, 1'b1);
      send_check("illegal_101", 32'h00500093, 3'b101, 5'd8, 32'h00000000, 1'b1);
`else
      send_check("illegal_111", 32'h00500093, 3'b111, 5'd7, 32'h00000005, 1'b0);
      send_check("illegal_101", 32'hFFF00093, 3'b101, 5'd8, 32'hFFFFFFFF, 1'b0);
`endif
   endtask

   task automatic test_back_to_back();
      logic [TAG_W-1:0] exp_seq [3];
      exp_seq[0] = 5'd1; exp_seq[1] = 5'd2; exp_seq[2] = 5'd3;
      out_ready = 1'b0;
      in_sel    = 3'b000;
      in_instr  = 32'h00100093;
      in_valid  = 1'b1;
      in_tag    = 5'd1;
      step();
      nvec++;
      if (in_ready !== 1'b1 || out_tag !== exp_seq[0]) begin
         $display("FAIL b2b_first: rdy=%b tag=%h, need 1 %h", in_ready, out_tag, exp_seq[0]);
         nerr++;
      end
      in_tag = 5'd2;
      step();
      nvec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== exp_seq[0]) begin
         $display("FAIL b2b_full: rdy=%b vld=%b tag=%h, need 0 1 %h", in_ready, out_valid, out_tag, exp_seq[0]);
         nerr++;
      end
      in_tag = 5'd3;
      step();
      nvec++;
      if (in_ready !== 1'b0 || out_tag !== exp_seq[0]) begin
         $display("FAIL b2b_stall: rdy=%b tag=%h, need 0 %h", in_ready, out_tag, exp_seq[0]);
         nerr++;
      end
      out_ready = 1'b1;
      step();
      nvec++;
      if (in_ready !== 1'b1 || out_tag !== exp_seq[1]) begin
         $display("FAIL b2b_drain1: rdy=%b tag=%h, need 1 %h", in_ready, out_tag, exp_seq[1]);
         nerr++;
      end
      step();
      in_valid = 1'b0;
      nvec++;
      if (out_valid !== 1'b1 || out_tag !== exp_seq[2]) begin
         $display("FAIL b2b_third: vld=%b tag=%h, need 1 %h", out_valid, out_tag, exp_seq[2]);
         nerr++;
      end
      step();
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL b2b_empty: vld=%b rdy=%b, need 0 1", out_valid, in_ready);
         nerr++;
      end
   endtask

   task automatic fill_full();
      out_ready = 1'b0;
      in_sel    = 3'b000;
      in_instr  = 32'h00300093;
      in_valid  = 1'b1;
      in_tag    = 5'd10;
      step();
      in_tag = 5'd11;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      fill_full();
      nvec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         $display("FAIL flush_prefill: rdy=%b vld=%b, need 0 1", in_ready, out_valid);
         nerr++;
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      in_tag   = 5'd12;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== '0) begin
         $display("FAIL flush_empty: vld=%b rdy=%b tag=%h, need 0 1 0", out_valid, in_ready, out_tag);
         nerr++;
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++;
         if (out_valid !== 1'b0) begin
            $display("FAIL flush_ghost: cycle %0d vld=%b tag=%h, need 0", i, out_valid, out_tag);
            nerr++;
         end
      end
   endtask

   task automatic test_reset_mid();
      fill_full();
      #2 reset = 1'b1;
      #1;
      nvec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== '0) begin
         $display("FAIL reset_async: vld=%b rdy=%b tag=%h, need 0 0 0", out_valid, in_ready, out_tag);
         nerr++;
      end
      step();
      #2 reset = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         nvec++;
         if (out_valid !== 1'b0) begin
            $display("FAIL reset_ghost: cycle %0d vld=%b tag=%h, need 0", i, out_valid, out_tag);
            nerr++;
         end
      end
      nvec++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_recover: in_ready=%b, need 1", in_ready);
         nerr++;
      end
   endtask

   initial begin
      test_reset();
      test_formation();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      send_check("post_reset_u", 32'h800000B7, 3'b100, 5'd13, 32'h80000000, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
